// File: rtl/mux2_sel_arbiter_pkg.sv
// Shared types and constants for the two-channel
// burst-limited arbiter that drives a Mux2.
package mux2_sel_arbiter_pkg;

  localparam int unsigned MAX_BURST_DEF = 4;
  localparam int unsigned BURST_W = 4;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } ch_e;

  typedef logic [BURST_W-1:0] burst_t;

  // Next burst length on a same-channel regrant.
  function automatic burst_t burst_inc(
    input burst_t cnt,
    input burst_t lim
  );
    burst_t r;
    r = (cnt < lim) ? cnt + 1'b1 : lim;
    return r;
  endfunction

  // Channel that is not ch.
  function automatic ch_e other_ch(input ch_e ch);
    ch_e r;
    r = (ch == CH0) ? CH1 : CH0;
    return r;
  endfunction

endpackage

// File: rtl/rr_burst_grant.sv
// Combinational two-way grant with a burst limit,
// plus the burst counter and last-grant pointer.
module rr_burst_grant
  import mux2_sel_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic in0_valid,
  input  logic in1_valid,
  input  logic slot_free,
  output logic in0_ready,
  output logic in1_ready
);

  localparam burst_t MAX_B = BURST_W'(MAX_BURST);

  // armed stays low for the first edge after reset
  // release so no grant leaves that cycle.
  logic   armed_q;
  ch_e    last_q;
  burst_t cnt_q;

  logic   gnt;
  ch_e    gnt_ch;
  burst_t cnt_d;
  logic   keep;

  // A count of zero means no burst is running,
  // so contention goes to the channel after last_q.
  assign keep = (cnt_q != '0) && (cnt_q < MAX_B);

  // Grant selection and next burst length.
  always_comb begin
    gnt    = 1'b0;
    gnt_ch = CH0;
    cnt_d  = cnt_q;
    if (armed_q && slot_free) begin
      unique case (1'b1)
        (in0_valid && in1_valid): begin
          gnt = 1'b1;
          if (keep) begin
            gnt_ch = last_q;
            cnt_d  = burst_inc(cnt_q, MAX_B);
          end else begin
            gnt_ch = other_ch(last_q);
            cnt_d  = burst_t'(1);
          end
        end
        (in0_valid && !in1_valid): begin
          gnt    = 1'b1;
          gnt_ch = CH0;
          cnt_d  = burst_t'(1);
        end
        (!in0_valid && in1_valid): begin
          gnt    = 1'b1;
          gnt_ch = CH1;
          cnt_d  = burst_t'(1);
        end
        default: begin
          gnt = 1'b0;
        end
      endcase
    end
  end

  assign in0_ready = gnt && (gnt_ch == CH0);
  assign in1_ready = gnt && (gnt_ch == CH1);

  // Pointer and burst state advance on each grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed_q <= 1'b0;
      last_q  <= CH1;
      cnt_q   <= '0;
    end else begin
      armed_q <= 1'b1;
      if (gnt) begin
        last_q <= gnt_ch;
        cnt_q  <= cnt_d;
      end
    end
  end

endmodule

// File: rtl/mux2_sel_arbiter.sv
// Arbitrates two 1-bit valid/ready channels into
// registered D0/D1/S legs for an external Mux2.
module mux2_sel_arbiter
  import mux2_sel_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic io_in0_valid,
  input  logic io_in0_bits,
  output logic io_in0_ready,
  input  logic io_in1_valid,
  input  logic io_in1_bits,
  output logic io_in1_ready,
  output logic io_D0,
  output logic io_D1,
  output logic io_S,
  output logic io_out_valid,
  input  logic io_out_ready
);

  logic slot_free;

  assign slot_free = !io_out_valid || io_out_ready;

  rr_burst_grant #(
    .MAX_BURST(MAX_BURST)
  ) u_grant (
    .clock    (clock),
    .reset    (reset),
    .in0_valid(io_in0_valid),
    .in1_valid(io_in1_valid),
    .slot_free(slot_free),
    .in0_ready(io_in0_ready),
    .in1_ready(io_in1_ready)
  );

  // Load the granted leg; the other leg holds.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_D0        <= 1'b0;
      io_D1        <= 1'b0;
      io_S         <= 1'b0;
      io_out_valid <= 1'b0;
    end else if (io_in0_ready) begin
      io_D0        <= io_in0_bits;
      io_S         <= CH0;
      io_out_valid <= 1'b1;
    end else if (io_in1_ready) begin
      io_D1        <= io_in1_bits;
      io_S         <= CH1;
      io_out_valid <= 1'b1;
    end else if (slot_free) begin
      io_out_valid <= 1'b0;
    end
  end

endmodule
